// File: rtl/alu_seq_sat.sv
// alu_seq_sat: sequential PID-term ALU sharing one datapath between the term sequencer
// and its term registers. Scaled add/sub (optional clamp) completes one cycle after accept.
// Signed fixed-point multiply runs one partial product per cycle over DW cycles.
// Optional feature macro: ALU_SAT_FLAG_EN adds the sat_hit output (clamp-applied flag).
//
// state | meaning
// IDLE  | ready for start; a captured add/sub may be completing
// MUL   | iterative multiply in progress, busy=1
module alu_seq_sat #(
   parameter int DW     = 16,
   parameter int SAT_W  = 12,
   parameter int FRAC   = 12,
   parameter int MSAT_W = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [1:0]    scale,
   input  logic          sat,
   input  logic [DW-1:0] src1,
   input  logic [DW-1:0] src0,
   output logic          busy,
   output logic          done,
`ifdef ALU_SAT_FLAG_EN
   output logic          sat_hit,
`endif
   output logic [DW-1:0] dst
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   // add/sub clamp bounds at the exact DW+3 bit sum width
   localparam logic signed [DW+2:0]   AS_MAX = (DW+3)'((64'd1 << (SAT_W-1)) - 64'd1);
   localparam logic signed [DW+2:0]   AS_MIN = ~AS_MAX;
   // multiply clamp bounds at the full product width
   localparam logic signed [2*DW-1:0] MS_MAX = (2*DW)'((64'd1 << (MSAT_W-1)) - 64'd1);
   localparam logic signed [2*DW-1:0] MS_MIN = ~MS_MAX;

   typedef enum logic {IDLE, MUL} state_t;

   state_t                  state;
   logic                    pend;
   logic signed [DW-1:0]    x_r;
   logic signed [DW+1:0]    y_r;
   logic                    sub_r;
   logic                    sat_r;
   logic signed [2*DW-1:0]  mcand;
   logic        [DW-1:0]    mplier;
   logic signed [2*DW-1:0]  acc;
   logic        [CW-1:0]    cnt;

   logic signed [DW+2:0]    sum_ext;
   logic                    as_hi, as_lo, as_clamped;
   logic        [DW-1:0]    as_res;
   logic signed [2*DW-1:0]  pp, acc_nxt, prod_sh;
   logic                    mul_hi, mul_lo, mul_clamped;
   logic        [DW-1:0]    mul_res;
   logic        [1:0]       sh;
   logic signed [DW+1:0]    y_in;

   // src0 pre-shift selected by scale at accept time
   always_comb begin
      sh = 2'd0;
      case (scale)
         2'b01:   sh = 2'd1;
         2'b10:   sh = 2'd2;
         default: sh = 2'd0;
      endcase
      y_in = $signed({{2{src0[DW-1]}}, src0}) <<< sh;
   end

   // exact scaled add/sub and its optional clamp to SAT_W
   always_comb begin
      if (sub_r)
         sum_ext = $signed({{3{x_r[DW-1]}}, x_r}) - $signed({y_r[DW+1], y_r});
      else
         sum_ext = $signed({{3{x_r[DW-1]}}, x_r}) + $signed({y_r[DW+1], y_r});
      as_hi      = sat_r && (sum_ext > AS_MAX);
      as_lo      = sat_r && (sum_ext < AS_MIN);
      as_clamped = as_hi || as_lo;
      if (as_hi)
         as_res = AS_MAX[DW-1:0];
      else if (as_lo)
         as_res = AS_MIN[DW-1:0];
      else
         as_res = sum_ext[DW-1:0];
   end

   // one radix-2 partial product per cycle; the multiplier sign bit carries negative weight
   always_comb begin
      pp = '0;
      if (mplier[0])
         pp = (cnt == '0) ? -mcand : mcand;
      acc_nxt     = acc + pp;
      prod_sh     = acc_nxt >>> FRAC;
      mul_hi      = prod_sh > MS_MAX;
      mul_lo      = prod_sh < MS_MIN;
      mul_clamped = mul_hi || mul_lo;
      if (mul_hi)
         mul_res = MS_MAX[DW-1:0];
      else if (mul_lo)
         mul_res = MS_MIN[DW-1:0];
      else
         mul_res = prod_sh[DW-1:0];
   end

   // sequencer FSM, operand capture and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         dst    <= '0;
         pend   <= 1'b0;
         x_r    <= '0;
         y_r    <= '0;
         sub_r  <= 1'b0;
         sat_r  <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
`ifdef ALU_SAT_FLAG_EN
         sat_hit <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef ALU_SAT_FLAG_EN
         sat_hit <= 1'b0;
`endif
         // captured add/sub completes one edge after accept
         if (pend) begin
            dst  <= as_res;
            done <= 1'b1;
            pend <= 1'b0;
`ifdef ALU_SAT_FLAG_EN
            sat_hit <= as_clamped;
`endif
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (op == 2'b10) begin
                     state  <= MUL;
                     busy   <= 1'b1;
                     mcand  <= $signed({{DW{src1[DW-1]}}, src1});
                     mplier <= src0;
                     acc    <= '0;
                     cnt    <= CW'(DW-1);
                  end else begin
                     x_r   <= $signed(src1);
                     y_r   <= y_in;
                     sub_r <= (op == 2'b01);
                     sat_r <= sat;
                     pend  <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand <<< 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  dst   <= mul_res;
`ifdef ALU_SAT_FLAG_EN
                  sat_hit <= mul_clamped;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef ALU_SAT_FLAG_EN
   // clamp indications only drive sat_hit when the flag is built in
   logic unused_flags;
   assign unused_flags = as_clamped ^ mul_clamped;
`endif

endmodule

// File: tb/tb_alu_seq_sat.sv
// Scoreboard bench for alu_seq_sat: stimulus pushes hand-computed results, a monitor
// pops and compares on every done pulse.
module tb_alu_seq_sat;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [1:0]  scale;
   logic        sat;
   logic [15:0] src1;
   logic [15:0] src0;
   logic        busy;
   logic        done;
   logic [15:0] dst;
   logic        sat_hit;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] d;
      logic        h;
      string       nm;
   } exp_t;

   exp_t sb[$];

   alu_seq_sat #(.DW(16), .SAT_W(12), .FRAC(12), .MSAT_W(15)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .scale (scale),
      .sat   (sat),
      .src1  (src1),
      .src0  (src0),
      .busy  (busy),
      .done  (done),
`ifdef ALU_SAT_FLAG_EN
      .sat_hit (sat_hit),
`endif
      .dst   (dst)
   );

`ifndef ALU_SAT_FLAG_EN
   assign sat_hit = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // monitor: every done pulse must match the oldest expected result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: dst=%h with no pending operation", dst);
            end else begin
               e = sb.pop_front();
               if (dst !== e.d) begin
                  errors++;
                  $display("FAIL %s dst: got %h expected %h", e.nm, dst, e.d);
               end
`ifdef ALU_SAT_FLAG_EN
               checks++;
               if (sat_hit !== e.h) begin
                  errors++;
                  $display("FAIL %s sat_hit: got %b expected %b", e.nm, sat_hit, e.h);
               end
`endif
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   // Drives one operation from the current negedge, then waits for its done pulse.
   // lat_exp counts negedges after the accept edge; busy_exp counts busy-high negedges.
   task automatic run_op(input logic [1:0] o, input logic [1:0] sc, input logic s,
                         input logic [15:0] a1, input logic [15:0] a0,
                         input logic [15:0] ed, input logic eh,
                         input int lat_exp, input int busy_exp, input bit intrude,
                         input string nm);
      int  lat;
      int  bcnt;
      bit  got;
      sb.push_back('{ed, eh, nm});
      start = 1'b1; op = o; scale = sc; sat = s; src1 = a1; src0 = a0;
      @(posedge clk);
      #1;
      start = 1'b0;
      src1 = 16'hDEAD; src0 = 16'hBEEF; op = 2'b00; sat = 1'b0; scale = 2'b00;
      lat = 0; bcnt = 0; got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (intrude) begin
            if (k == 5) begin
               start = 1'b1; op = 2'b00; src1 = 16'h1111; src0 = 16'h2222;
            end else begin
               start = 1'b0;
            end
         end
         if (busy) bcnt++;
         if (done) begin
            got = 1'b1;
            lat = k;
         end
      end
      start = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no done within 40 cycles", nm);
      end else begin
         chk({nm, "_latency"}, 16'(lat), 16'(lat_exp));
         chk({nm, "_busy_cycles"}, 16'(bcnt), 16'(busy_exp));
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; op = 2'b00; scale = 2'b00; sat = 1'b0;
      src1 = 16'h0; src0 = 16'h0;
      #2 rst = 1'b1;
      #1;
      chk("reset_busy", {15'd0, busy}, 16'h0);
      chk("reset_done", {15'd0, done}, 16'h0);
      chk("reset_dst", dst, 16'h0000);
`ifdef ALU_SAT_FLAG_EN
      chk("reset_sat_hit", {15'd0, sat_hit}, 16'h0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // op, scale, sat, src1, src0, dst, sat_hit, latency, busy cycles, intrude
      run_op(2'b00, 2'b00, 1'b1, 16'h07F0, 16'h0020, 16'h07FF, 1'b1, 2, 0, 1'b0, "add_sat_hi");
      run_op(2'b01, 2'b10, 1'b0, 16'h0010, 16'h0003, 16'h0004, 1'b0, 2, 0, 1'b0, "sub_x4");
      run_op(2'b01, 2'b00, 1'b1, 16'hF900, 16'h0200, 16'hF800, 1'b1, 2, 0, 1'b0, "sub_sat_lo");
      run_op(2'b10, 2'b00, 1'b0, 16'h1000, 16'hF000, 16'hF000, 1'b0, 17, 16, 1'b1, "mul_neg_intrude");
      run_op(2'b10, 2'b00, 1'b0, 16'h7FFF, 16'h7FFF, 16'h3FFF, 1'b1, 17, 16, 1'b0, "mul_max_max");
      run_op(2'b10, 2'b11, 1'b1, 16'h8000, 16'h7FFF, 16'hC000, 1'b1, 17, 16, 1'b0, "mul_min_max");
      run_op(2'b00, 2'b00, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 2, 0, 1'b0, "add_wrap");
      run_op(2'b00, 2'b01, 1'b1, 16'h0100, 16'h0100, 16'h0300, 1'b0, 2, 0, 1'b0, "add_x2_insat");
      run_op(2'b11, 2'b00, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 2, 0, 1'b0, "rsvd_as_add");
      run_op(2'b10, 2'b00, 1'b0, 16'h8000, 16'h8000, 16'h3FFF, 1'b1, 17, 16, 1'b0, "mul_min_min");
      run_op(2'b01, 2'b10, 1'b1, 16'h8000, 16'h7FFF, 16'hF800, 1'b1, 2, 0, 1'b0, "sub_extreme");
      run_op(2'b10, 2'b00, 1'b0, 16'h0800, 16'h0600, 16'h0300, 1'b0, 17, 16, 1'b0, "mul_frac");
      run_op(2'b10, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17, 16, 1'b0, "mul_floor");

      // reset 5 cycles into a multiply: abort with no done and dst cleared
      start = 1'b1; op = 2'b10; src1 = 16'h7FFF; src0 = 16'h7FFF;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      chk("mul_busy_before_rst", {15'd0, busy}, 16'h1);
      rst = 1'b1;
      #1;
      chk("abort_busy", {15'd0, busy}, 16'h0);
      chk("abort_done", {15'd0, done}, 16'h0);
      chk("abort_dst", dst, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      run_op(2'b00, 2'b00, 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 2, 0, 1'b0, "add_after_abort");

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", 16'(sb.size()), 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
